// File: rtl/init_sequencer.sv
// init_sequencer: parametrised start-up controller for a set of init channels
// (camera SCCB, HDMI I2C, further peripherals) using a one-cycle start pulse
// and a done level per channel. Channels are launched together (SEQ_MODE=0)
// or strictly one at a time in index order (SEQ_MODE=1). Completion is gated
// by an external readiness level (memory calibration).
//
// Build option: define INIT_SEQ_TIMEOUT_EN to add the per-attempt timeout
// counter, the retry logic and the ch_fail/error reporting. Without it every
// enabled channel is waited on indefinitely and ch_fail/error read as 0.
module init_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int SEQ_MODE    = 0,
  parameter int TIMEOUT_W   = 24,
  parameter int TIMEOUT_CYC = 12_500_000,
  parameter int MAX_RETRY   = 2,
  parameter int RETRY_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              ext_ready,
  output logic [NUM_CH-1:0] ch_start,
  input  logic [NUM_CH-1:0] ch_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [NUM_CH-1:0] ch_ok,
  output logic [NUM_CH-1:0] ch_fail
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_NEXT,
    S_EXT,
    S_DONE
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] en_q;
  logic [PTR_W-1:0]  ptr;

  // One-hot select of a channel index.
  function automatic logic [NUM_CH-1:0] onehot(input logic [PTR_W-1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

  logic [PTR_W-1:0]  ptr_nxt;
  logic [NUM_CH-1:0] ptr_oh;
  logic [NUM_CH-1:0] ptr_nxt_oh;
  logic [NUM_CH-1:0] pend_now;
  logic [NUM_CH-1:0] ok_par;
  logic [NUM_CH-1:0] pend_par;
  logic              done_seq;

  assign ptr_nxt    = ptr + PTR_W'(1);
  assign ptr_oh     = onehot(ptr);
  assign ptr_nxt_oh = onehot(ptr_nxt);

  // Channels still owed a launch: enabled and not yet resolved either way.
  assign pend_now = en_q & ~ch_ok & ~ch_fail;

  // Parallel mode: ok set including this cycle's done levels, and what is
  // still outstanding after them. A done on a disabled channel never counts.
  assign ok_par   = ch_ok | (en_q & ch_done & ~ch_fail);
  assign pend_par = en_q & ~ok_par & ~ch_fail;

  // Sequential mode: completion of the channel under the pointer.
  assign done_seq = |(ch_done & en_q & ptr_oh);

`ifdef INIT_SEQ_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LAST   = TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0]   RETRY_MAX = RETRY_W'(MAX_RETRY);

  logic [TIMEOUT_W-1:0] to_cnt;
  logic [RETRY_W-1:0]   retry;
  logic [NUM_CH-1:0]    fail_q;
  logic                 error_q;
  logic                 timeout_hit;
  logic                 retry_left;

  // The attempt expires on the last allowed WAIT cycle; a done level seen in
  // that same cycle takes priority because it is checked first in the FSM.
  assign timeout_hit = (to_cnt == TO_LAST);
  assign retry_left  = (retry < RETRY_MAX);

  assign ch_fail = fail_q;
  assign error   = error_q;
`else
  assign ch_fail = '0;
  assign error   = 1'b0;
`endif

  // Sequencer FSM; ch_start is a registered one-cycle pulse that is high
  // exactly while the FSM sits in S_LAUNCH for that attempt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      en_q     <= '0;
      ptr      <= '0;
      ch_start <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ch_ok    <= '0;
`ifdef INIT_SEQ_TIMEOUT_EN
      to_cnt   <= '0;
      retry    <= '0;
      fail_q   <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      ch_start <= '0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            en_q  <= ch_en;
            ptr   <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            ch_ok <= '0;
`ifdef INIT_SEQ_TIMEOUT_EN
            to_cnt  <= '0;
            retry   <= '0;
            fail_q  <= '0;
            error_q <= 1'b0;
`endif
            // Results are cleared in the same edge, so every enabled
            // channel (or channel 0 alone in sequential mode) is launched.
            if (SEQ_MODE != 0) ch_start <= ch_en & onehot('0);
            else               ch_start <= ch_en;
            state <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
`ifdef INIT_SEQ_TIMEOUT_EN
          to_cnt <= '0;
`endif
          if (SEQ_MODE != 0) begin
            // Only index 0 can arrive here disabled (straight from start).
            if (|(en_q & ptr_oh)) state <= S_WAIT;
            else if (en_q == '0)  state <= S_EXT;
            else                  state <= S_NEXT;
          end else begin
            if (pend_now == '0) state <= S_EXT;
            else                state <= S_WAIT;
          end
        end

        S_WAIT: begin
`ifdef INIT_SEQ_TIMEOUT_EN
          to_cnt <= to_cnt + TIMEOUT_W'(1);
`endif
          if (SEQ_MODE != 0) begin
            if (done_seq) begin
              ch_ok <= ch_ok | ptr_oh;
              state <= S_NEXT;
`ifdef INIT_SEQ_TIMEOUT_EN
              retry <= '0;
`endif
            end
`ifdef INIT_SEQ_TIMEOUT_EN
            else if (timeout_hit) begin
              if (retry_left) begin
                retry    <= retry + RETRY_W'(1);
                ch_start <= ptr_oh;
                state    <= S_LAUNCH;
              end else begin
                // A failed channel does not stop the walk through the list.
                fail_q <= fail_q | ptr_oh;
                retry  <= '0;
                state  <= S_NEXT;
              end
            end
`endif
          end else begin
            ch_ok <= ok_par;
            if (pend_par == '0) begin
              state <= S_EXT;
            end
`ifdef INIT_SEQ_TIMEOUT_EN
            else if (timeout_hit) begin
              if (retry_left) begin
                // Only channels still outstanding are re-pulsed.
                retry    <= retry + RETRY_W'(1);
                ch_start <= pend_par;
                state    <= S_LAUNCH;
              end else begin
                fail_q <= fail_q | pend_par;
                state  <= S_EXT;
              end
            end
`endif
          end
        end

        S_NEXT: begin
          // Advance one index per cycle; the pointer never wraps.
          if (ptr == PTR_LAST) begin
            state <= S_EXT;
          end else begin
            ptr <= ptr_nxt;
            if (|(en_q & ptr_nxt_oh)) begin
              ch_start <= ptr_nxt_oh;
              state    <= S_LAUNCH;
            end
          end
        end

        S_EXT: begin
          // No timeout here: external readiness is waited on indefinitely.
          if (ext_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
`ifdef INIT_SEQ_TIMEOUT_EN
            error_q <= |fail_q;
`endif
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_init_sequencer.sv
// Directed bench for init_sequencer: a parallel and a sequential instance
// with three channels, short timeout and a single retry.
module tb_init_sequencer;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start_p, ext_p, busy_p, done_p, err_p;
  logic [N-1:0] en_p, din_p, chs_p, ok_p, fail_p;
  logic         start_s, ext_s, busy_s, done_s, err_s;
  logic [N-1:0] en_s, din_s, chs_s, ok_s, fail_s;

  int total = 0;
  int bad   = 0;
  bit seen_s1;
  logic [N-1:0] any_pulse;

  init_sequencer #(
    .NUM_CH(N), .SEQ_MODE(0), .TIMEOUT_W(8), .TIMEOUT_CYC(10),
    .MAX_RETRY(1), .RETRY_W(2)
  ) dut_p (
    .clk(clk), .reset(reset), .start(start_p), .ch_en(en_p),
    .ext_ready(ext_p), .ch_start(chs_p), .ch_done(din_p), .busy(busy_p),
    .done(done_p), .error(err_p), .ch_ok(ok_p), .ch_fail(fail_p)
  );

  init_sequencer #(
    .NUM_CH(N), .SEQ_MODE(1), .TIMEOUT_W(8), .TIMEOUT_CYC(10),
    .MAX_RETRY(1), .RETRY_W(2)
  ) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .ch_en(en_s),
    .ext_ready(ext_s), .ch_start(chs_s), .ch_done(din_s), .busy(busy_s),
    .done(done_s), .error(err_s), .ch_ok(ok_s), .ch_fail(fail_s)
  );

  always @(posedge clk) if (chs_s[1]) seen_s1 <= 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    reset = 1'b1;
    start_p = 0; ext_p = 0; en_p = '0; din_p = '0;
    start_s = 0; ext_s = 0; en_s = '0; din_s = '0;
    tick(); tick();
    chk("rst_chs_p", chs_p, 0);
    chk("rst_busy_p", busy_p, 0);
    chk("rst_done_p", done_p, 0);
    chk("rst_err_p", err_p, 0);
    chk("rst_ok_p", ok_p, 0);
    chk("rst_fail_p", fail_p, 0);
    chk("rst_chs_s", chs_s, 0);
    chk("rst_busy_s", busy_s, 0);
    reset = 1'b0;
    tick();

    // Parallel happy path with staggered done levels
    en_p = 3'b111; ext_p = 1; din_p = '0; start_p = 1;
    tick();
    chk("p_launch_pulse", chs_p, 3'b111);
    chk("p_busy_on", busy_p, 1);
    start_p = 0;
    tick();
    chk("p_pulse_one_cycle", chs_p, 0);
    din_p = 3'b001;
    tick();
    chk("p_ok0", ok_p, 3'b001);
    tick(); tick();
    din_p[2] = 1'b1;
    tick();
    chk("p_ok02", ok_p, 3'b101);
    tick();
    din_p[1] = 1'b1;
    tick();
    chk("p_ok_all", ok_p, 3'b111);
    chk("p_done_not_yet", done_p, 0);
    tick();
    chk("p_done", done_p, 1);
    chk("p_busy_off", busy_p, 0);
    chk("p_err", err_p, 0);
    chk("p_fail", fail_p, 0);

    // Restart from done with a partial enable; start held while busy
    din_p = '0; en_p = 3'b011; start_p = 1;
    tick();
    chk("r_done_clr", done_p, 0);
    chk("r_ok_clr", ok_p, 0);
    chk("r_pulse", chs_p, 3'b011);
    tick();
    chk("r_no_relaunch", chs_p, 0);
    chk("r_busy", busy_p, 1);
    start_p = 0; din_p = 3'b111;
    tick();
    chk("r_disabled_ignored", ok_p, 3'b011);
    tick();
    chk("r_done", done_p, 1);

    // ext_ready gating
    din_p = '0; en_p = 3'b111; ext_p = 0; start_p = 1;
    tick();
    start_p = 0;
    tick();
    din_p = 3'b111;
    tick();
    chk("x_ok_all", ok_p, 3'b111);
    repeat (8) tick();
    chk("x_busy_held", busy_p, 1);
    chk("x_done_held", done_p, 0);
    ext_p = 1;
    tick();
    chk("x_done", done_p, 1);
    chk("x_busy_off", busy_p, 0);

    // All enables zero: done three cycles after start is sampled
    en_p = '0; din_p = '0; start_p = 1;
    tick();
    chk("z_no_pulse", chs_p, 0);
    chk("z_busy", busy_p, 1);
    chk("z_done_c1", done_p, 0);
    start_p = 0;
    tick();
    chk("z_done_c2", done_p, 0);
    tick();
    chk("z_done_c3", done_p, 1);
    chk("z_ok", ok_p, 0);

`ifdef INIT_SEQ_TIMEOUT_EN
    // Retry then fail on channel 1; then restart clears the error
    en_p = 3'b111; din_p = '0; ext_p = 1; start_p = 1;
    tick();
    chk("t_pulse1", chs_p, 3'b111);
    start_p = 0; din_p = 3'b101;
    tick();
    chk("t_done_before_wait", ok_p, 0);
    tick();
    chk("t_ok02", ok_p, 3'b101);
    repeat (8) tick();
    chk("t_quiet", chs_p, 0);
    tick();
    chk("t_retry_pulse", chs_p, 3'b010);
    tick();
    chk("t_retry_one_cycle", chs_p, 0);
    repeat (9) tick();
    chk("t_not_failed_yet", fail_p, 0);
    tick();
    chk("t_fail", fail_p, 3'b010);
    chk("t_done_not_yet", done_p, 0);
    tick();
    chk("t_done", done_p, 1);
    chk("t_err", err_p, 1);
    chk("t_ok_final", ok_p, 3'b101);
    din_p = '0; start_p = 1;
    tick();
    chk("t_err_clr", err_p, 0);
    chk("t_fail_clr", fail_p, 0);
    chk("t_done_clr", done_p, 0);
    chk("t_repulse", chs_p, 3'b111);
    start_p = 0; din_p = 3'b111;
    tick(); tick();
    chk("t_ok_restart", ok_p, 3'b111);
    tick();
    chk("t_done_restart", done_p, 1);
    chk("t_err_restart", err_p, 0);
`else
    // Without timeouts a silent channel is waited on indefinitely
    en_p = 3'b010; din_p = '0; ext_p = 1; start_p = 1;
    tick();
    start_p = 0;
    repeat (40) tick();
    chk("n_busy", busy_p, 1);
    chk("n_done", done_p, 0);
    chk("n_fail", fail_p, 0);
    chk("n_err", err_p, 0);
    din_p = 3'b010;
    tick();
    chk("n_ok", ok_p, 3'b010);
    tick();
    chk("n_done_late", done_p, 1);
    chk("n_err_late", err_p, 0);
`endif

    // Sequential mode with channel 1 skipped
    en_s = 3'b101; ext_s = 1; din_s = '0; start_s = 1;
    tick();
    chk("s_pulse0", chs_s, 3'b001);
    start_s = 0;
    tick();
    chk("s_pulse0_end", chs_s, 0);
    tick(); tick();
    chk("s_ch2_waits", chs_s, 0);
    din_s = 3'b001;
    tick();
    chk("s_ok0", ok_s, 3'b001);
    tick();
    chk("s_skip1", chs_s, 0);
    tick();
    chk("s_pulse2", chs_s, 3'b100);
    tick();
    chk("s_pulse2_end", chs_s, 0);
    din_s = 3'b101;
    tick();
    chk("s_ok02", ok_s, 3'b101);
    tick();
    chk("s_done_not_yet", done_s, 0);
    tick();
    chk("s_done", done_s, 1);
    chk("s_ch1_never", seen_s1, 0);

    // Reset in the middle of WAIT
    din_p = '0; en_p = 3'b111; ext_p = 1; start_p = 1;
    tick();
    start_p = 0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("m_busy", busy_p, 0);
    chk("m_done", done_p, 0);
    chk("m_chs", chs_p, 0);
    chk("m_ok", ok_p, 0);
    chk("m_fail", fail_p, 0);
    chk("m_err", err_p, 0);
    reset = 1'b0;
    any_pulse = '0;
    repeat (12) begin
      tick();
      any_pulse = any_pulse | chs_p;
    end
    chk("m_no_pulse", any_pulse, 0);
    chk("m_idle", busy_p, 0);
    start_p = 1;
    tick();
    start_p = 0;
    chk("m_relaunch", chs_p, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/init_sequencer.md
Name:
init_sequencer

Overview:
- Parametrised system-initialisation controller; next generation of the fixed camera/HDMI/memory start-up sequencer.
- Drives a configurable number of init channels (camera SCCB, HDMI I2C, and further peripherals) through a start-pulse/done-level handshake.
- Runs channels in parallel or strictly in index order, with per-channel enable, timeout, retry and pass/fail status.
- Sits beneath the top level; external readiness (memory calibration) gates final completion.

Parameters:
- NUM_CH, 4: number of init channels.
- SEQ_MODE, 0: 0 = launch all enabled channels together; 1 = launch one at a time, index 0 upward.
- TIMEOUT_W, 24: width of the timeout counter.
- TIMEOUT_CYC, 12_500_000: clk cycles allowed per WAIT attempt (TIMEOUT_W bits).
- MAX_RETRY, 2: re-launches allowed after the first timeout; 0 = no retry.
- RETRY_W, 2: width of the retry counter; must hold MAX_RETRY.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- start  in  1  begin the sequence; sampled only in S_IDLE or S_DONE.
- ch_en  in  NUM_CH  per-channel enable; sampled once, when start is accepted.
- ext_ready  in  1  external readiness (memory init done); level.
- ch_start  out  NUM_CH  one-cycle launch pulse per channel.
- ch_done  in  NUM_CH  per-channel completion; level.
- busy  out  1  high from start acceptance until done.
- done  out  1  level; high from completion until the next accepted start or reset.
- error  out  1  level; valid while done is high; set if any enabled channel failed.
- ch_ok  out  NUM_CH  per-channel completed-successfully flags.
- ch_fail  out  NUM_CH  per-channel failed-after-retries flags.

Behaviour:
- Reset: state = S_IDLE. ch_start, busy, done, error, ch_ok and ch_fail are all 0. Timeout counter, retry counter and pointer are 0. Reset mid-sequence aborts at once; no further ch_start pulses are issued.
- States: S_IDLE, S_LAUNCH, S_WAIT, S_NEXT (SEQ_MODE=1 only), S_EXT, S_DONE.
- Start acceptance: start is accepted in S_IDLE or S_DONE.
  - On acceptance: latch ch_en into en_q; clear done, error, ch_ok and ch_fail; set busy; go to S_LAUNCH.
  - start is ignored while busy.
- Parallel mode (SEQ_MODE=0):
  - S_LAUNCH: pulse ch_start for every enabled channel that is neither ok nor failed. Clear the timeout counter. Go to S_WAIT.
  - S_WAIT: each cycle, ch_ok[i] is set when en_q[i] and ch_done[i] are both high. ch_done is first sampled in the cycle after the ch_start pulse.
  - S_WAIT exits to S_EXT when every enabled channel is ok or failed.
  - Timeout: when the counter reaches TIMEOUT_CYC-1 with channels still pending:
    - if retry < MAX_RETRY: increment retry and return to S_LAUNCH; only pending channels are re-pulsed.
    - otherwise: set ch_fail on all pending channels and go to S_EXT.
  - ch_done and timeout in the same cycle: ch_done wins, and that channel is ok.
- Sequential mode (SEQ_MODE=1):
  - The pointer starts at 0. S_NEXT skips disabled indices one per cycle.
  - For the current channel, S_LAUNCH pulses only ch_start[ptr], then S_WAIT waits on ch_done[ptr].
  - Timeout and retry apply per channel; the retry counter is cleared on entering S_NEXT.
  - A failed channel does not abort: the sequence continues with the next index.
  - After index NUM_CH-1 the pointer does not wrap; go to S_EXT.
- S_EXT: wait, with no timeout, for ext_ready high, then go to S_DONE.
- S_DONE:
  - done = 1; busy = 0; error = OR of ch_fail.
  - ch_ok and ch_fail hold until the next accepted start.
- All enables zero: go straight to S_EXT. With ext_ready high, done rises 3 cycles after start is sampled.
- Latency: the ch_start pulse appears in the cycle after start is sampled. done rises 2 cycles after the final ch_done is sampled when ext_ready is already high.
- ch_done on a disabled or already-ok channel is ignored. ch_done before launch is not counted.

Optional Feature:
- Macro INIT_SEQ_TIMEOUT_EN.
- Defined: timeout counter, retry logic and ch_fail/error are implemented as described above.
- Undefined:
  - No counter or retry logic.
  - S_WAIT waits indefinitely for every enabled channel.
  - ch_fail and error are tied to 0.
  - TIMEOUT_* and MAX_RETRY are unused.

Test Plan:
- Parallel happy path (NUM_CH=3, ch_en=3'b111, ext_ready=1): start; ch_done[0,1,2] rise at cycles 5, 9, 7 → ch_start=3'b111 for one cycle; done=1 at cycle 11; ch_ok=3'b111; error=0.
- Retry then fail (TIMEOUT_CYC=100, MAX_RETRY=1, ch1 never done) → ch_start[1] pulses twice, 100 cycles apart; done after about 200 cycles; ch_fail=3'b010; error=1; ch_ok=3'b101.
- Sequential with skip (SEQ_MODE=1, ch_en=3'b101) → ch_start[0] first; ch_start[2] only after ch_done[0]; ch_start[1] never pulses; ch_ok=3'b101.
- ext_ready gating: all channels done at cycle 6 while ext_ready is held low until cycle 50 → done rises at cycle 52; busy stays 1 until then.
- Reset mid-WAIT: reset asserted at cycle 20 → next cycle all outputs are 0, state is idle, and no ch_start is issued until a new start.
- Restart from S_DONE with error=1: new start → error, ch_fail and done clear the next cycle, and enabled channels are re-pulsed.
